// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: host-link UART transmitter with a byte FIFO, 8N1 framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_buffer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               tx_DI,
    input  logic                     tx_wr,
    input  logic                     tx_clear,
    output logic                     tx_full,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic                     busy,
    output logic                     overflow,
    output logic                     send_done,
    output logic                     uart_port_DO
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LP_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   LP_DEPTH  = (AW+1)'(DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          r_done;

    logic          w_empty;
    logic          w_full;
    logic          w_bit_end;
    logic          w_pop;
    logic          w_push;
    logic          w_line;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == LP_DEPTH);
    assign w_bit_end = (r_cnt == '0);
    // The head byte leaves the FIFO when the line is idle or a stop bit ends.
    assign w_pop     = !w_empty &&
                       ((r_state == S_IDLE) ||
                        ((r_state == S_STOP) && w_bit_end));
    // A write into a full FIFO still fits if the head leaves on the same edge.
    assign w_push    = tx_wr && !tx_clear && (!w_full || w_pop);

    assign tx_full   = w_full;
    assign tx_count  = r_count;
    assign overflow  = r_ovf;
    assign send_done = r_done;
    assign busy      = (r_state != S_IDLE);
    assign uart_port_DO = w_line;

    // Storage array; written only on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wptr] <= tx_DI;
        end
    end

    // FIFO pointers, occupancy and sticky overflow; a flush beats everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (tx_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + (AW+1)'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - (AW+1)'(1);
            if (tx_wr && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    // Frame sequencer: bit timing, bit index, shifter load and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
                        r_cnt   <= LP_RELOAD;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= LP_RELOAD;
                        r_idx   <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= LP_RELOAD;
                        if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= LP_RELOAD;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_shift <= r_mem[r_rptr];
                            r_cnt   <= LP_RELOAD;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Line level follows the state directly so reset forces it high at once.
    always_comb begin
        w_line = 1'b1;
        unique case (r_state)
            S_START:  w_line = 1'b0;
            S_DATA:   w_line = r_shift[r_idx];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_line = ^r_shift;
`endif
            default:  w_line = 1'b1;
        endcase
    end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Transmit end of the host-link UART. Sends status and verification bytes ('S' 0x53 success, 'F' 0x46 failure) and later debug/readback data from the NES controller FSM to the host.
- Accepts bytes through a write strobe into a small FIFO and serialises them 8N1 on uart_port_DO.
- Reports completion with a send_done pulse, which the controller FSM uses to leave VERIFICATION_END.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range is 2 or more.
DEPTH, 16, FIFO depth in bytes; power of two, 2 or more.

Ports:
clk  input  1  system clock (CLOCK_50 domain)
rst_n  input  1  asynchronous active-low reset
tx_DI  input  8  byte to enqueue
tx_wr  input  1  enqueue strobe, sampled on rising clk
tx_clear  input  1  synchronous FIFO flush
tx_full  output  1  FIFO holds DEPTH bytes
tx_count  output  $clog2(DEPTH)+1  bytes waiting in FIFO (excludes byte in shifter)
busy  output  1  a frame is on the line
overflow  output  1  sticky: a write was dropped while full
send_done  output  1  one-cycle pulse: last frame finished, FIFO empty
uart_port_DO  output  1  serial line, idle high

Behaviour:
- Reset (rst_n low, async):
  - uart_port_DO=1, busy=0, send_done=0, overflow=0, tx_full=0, tx_count=0.
  - FIFO pointers cleared; FSM goes to IDLE immediately, even mid-frame. The line returns high at once and the truncated frame is not resumed.
- FSM states:
  - IDLE: line=1. If FIFO is non-empty, pop the head into the shifter, load the bit counter with CLKS_PER_BIT-1, go to START.
  - START: line=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: line=shifter[idx], LSB first, CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: line=1 for CLKS_PER_BIT cycles. At the end of STOP:
    - FIFO non-empty: pop and go directly to START. No idle gap; back-to-back frames are exactly 10*CLKS_PER_BIT cycles apart.
    - FIFO empty: go to IDLE and assert send_done for one cycle on that same edge.
- busy=1 in START, DATA and STOP.
- Latency: a write accepted at edge N into an empty FIFO while IDLE produces a pop at edge N+1. The line goes low after edge N+1, and the start bit lasts exactly CLKS_PER_BIT cycles.
- FIFO:
  - Write when tx_full=0: store and increment count.
  - Write when tx_full=1: byte dropped, overflow<=1. overflow holds until tx_clear or reset.
  - Push and pop on the same edge: both occur and the count is unchanged. A push on a full FIFO coincident with a pop is accepted.
  - Pointers wrap modulo DEPTH. tx_full = (tx_count==DEPTH).
- tx_clear:
  - Empties the FIFO (count=0) and clears overflow.
  - Does not abort the frame in the shifter; that frame completes normally and send_done fires at its end.
  - tx_clear and tx_wr on the same edge: clear wins and the byte is discarded.
  - tx_clear while IDLE with an empty FIFO: no send_done.
- send_done never asserts while busy=0 except on the STOP-to-IDLE edge. It never asserts for dropped bytes.

Optional Feature:
- UART_TX_PARITY_EN
- Defined:
  - A PARITY state sits between DATA and STOP and drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame is 11 bits; back-to-back spacing is 11*CLKS_PER_BIT cycles.
- Undefined: the PARITY state is absent and the frame is 8N1 (10 bits).

Test Plan:
1. CLKS_PER_BIT=4: write 0x53 once into the idle block.
   - Line is low for cycles 2-5 after the write edge, then data bits 1,1,0,0,1,0,1,0 (4 cycles each), then high for 4 cycles.
   - send_done pulses once, 42 cycles after the write edge; busy is high throughout.
2. Write 0x4E, 0x45, 0x53, 0x1A on consecutive cycles.
   - Four contiguous frames of 40 cycles each, no idle gap between them.
   - Decoded bytes arrive in order; send_done pulses once, only after 0x1A.
3. DEPTH=4: write 6 bytes on consecutive cycles.
   - tx_full=1 at the 5th write; the 6th is dropped and overflow=1.
   - Exactly 5 frames are transmitted.
   - A subsequent tx_clear drops overflow to 0.
4. Write 3 bytes, then assert tx_clear during the DATA state of byte 0.
   - Byte 0 completes intact and send_done pulses at its stop end.
   - Bytes 1 and 2 are never sent; tx_count reads 0 after the clear.
5. Assert rst_n=0 mid-DATA while the line is low.
   - uart_port_DO=1 and busy=0 without waiting for a clock edge.
   - After release, a fresh write of 0x46 transmits a correct frame.
6. With UART_TX_PARITY_EN defined, write 0x53 (four 1s).
   - Parity bit is 0 and the frame is 44 cycles.
   - 0x46 (three 1s) gives parity bit 1.
